aux_display_reader: RTL and testbench

Consumer side of the auxiliary display memory. `data_manager` fills the memory during vertical blanking. This block reads it back during the active frame and streams each 16-bit word as hexadecimal nibbles to the character renderer over a valid/ready handshake. It sits between the aux memory read port 0 and the text/glyph pipeline of the VGA controller.

---
 rtl/aux_display_reader.sv | 148 ++++++++++++++
 tb/tb_aux_display_reader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aux_display_reader.sv
// aux_display_reader: reads aux display memory during the active frame and
// streams each word as hex nibbles (MS first) over a valid/ready handshake.
// Latency: first digit valid 3 cycles after v_sync_in is first sampled high;
// then one nibble per cycle while ready, plus 2 overhead cycles per entry.
// Backpressure: digit_out/last/index hold while valid & !ready; valid drops
// only after a transfer, on blanking (v_sync_in low) or on reset.
//
// Ports:
//   clock_in, reset_in (async active-low), v_sync_in (low = blanking)
//   aux_data_in / aux_raddress_out : aux memory read port (1-cycle latency)
//   digit_out, digit_valid_out, digit_ready_in, digit_last_out : nibble stream
//   entry_index_out : entry being emitted; frame_done_out : frame finished
//
// Optional feature macro: AUX_READER_ZERO_SUPPRESS_EN (skip leading zero
// nibbles of each entry; an all-zero word still emits a single 0).

module aux_display_reader #(
  parameter int DATA_WIDTH        = 16,
  parameter int AUX_ADDRESS_WIDTH = 5,
  parameter int AUX_ELEMENTS      = 10
) (
  input  logic                         clock_in,
  input  logic                         reset_in,
  input  logic                         v_sync_in,
  input  logic [DATA_WIDTH-1:0]        aux_data_in,
  output logic [AUX_ADDRESS_WIDTH-1:0] aux_raddress_out,
  output logic [3:0]                   digit_out,
  output logic                         digit_valid_out,
  input  logic                         digit_ready_in,
  output logic                         digit_last_out,
  output logic [AUX_ADDRESS_WIDTH-1:0] entry_index_out,
  output logic                         frame_done_out
);

  localparam int NIBBLES = DATA_WIDTH / 4;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);
  localparam logic [AUX_ADDRESS_WIDTH-1:0] LAST_IDX = AUX_ADDRESS_WIDTH'(AUX_ELEMENTS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]                   state;
  logic [DATA_WIDTH-1:0]        shift_reg;
  logic [CW-1:0]                count;
  logic [AUX_ADDRESS_WIDTH-1:0] index;

  // Word and starting nibble count as captured in LOAD.
  logic [DATA_WIDTH-1:0] load_data;
  logic [CW-1:0]         load_count;

`ifdef AUX_READER_ZERO_SUPPRESS_EN
  logic zero_run;

  // Count leading zero nibbles, never skipping the final nibble, so an
  // all-zero word still produces one '0' digit flagged as last.
  always_comb begin
    load_count = '0;
    zero_run   = 1'b1;
    for (int i = 0; i < NIBBLES - 1; i++) begin
      if (zero_run && (aux_data_in[DATA_WIDTH-1-4*i -: 4] == 4'h0)) begin
        load_count = load_count + CW'(1);
      end else begin
        zero_run = 1'b0;
      end
    end
    load_data = aux_data_in << (4 * load_count);
  end
`else
  assign load_data  = aux_data_in;
  assign load_count = '0;
`endif

  assign digit_out       = shift_reg[DATA_WIDTH-1 -: 4];
  assign entry_index_out = index;

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state            <= S_IDLE;
      shift_reg        <= '0;
      count            <= '0;
      index            <= '0;
      aux_raddress_out <= '0;
      digit_valid_out  <= 1'b0;
      digit_last_out   <= 1'b0;
      frame_done_out   <= 1'b0;
    end else if (!v_sync_in) begin
      // Blanking wins over everything, including a pending handshake:
      // the writer owns the memory, so any nibble in flight is dropped.
      state            <= S_IDLE;
      index            <= '0;
      aux_raddress_out <= '0;
      digit_valid_out  <= 1'b0;
      digit_last_out   <= 1'b0;
      frame_done_out   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // Address is presented on entry to ADDR so the read data is
          // available by the time LOAD captures it.
          aux_raddress_out <= '0;
          state            <= S_ADDR;
        end
        S_ADDR: begin
          state <= S_LOAD;
        end
        S_LOAD: begin
          shift_reg       <= load_data;
          count           <= load_count;
          digit_last_out  <= (load_count == LAST_CNT);
          digit_valid_out <= 1'b1;
          state           <= S_SHIFT;
        end
        S_SHIFT: begin
          if (digit_valid_out && digit_ready_in) begin
            shift_reg <= shift_reg << 4;
            count     <= count + CW'(1);
            if (digit_last_out) begin
              digit_valid_out <= 1'b0;
              digit_last_out  <= 1'b0;
              if (index == LAST_IDX) begin
                state <= S_DONE;
              end else begin
                index            <= index + AUX_ADDRESS_WIDTH'(1);
                aux_raddress_out <= index + AUX_ADDRESS_WIDTH'(1);
                state            <= S_ADDR;
              end
            end else begin
              digit_last_out <= ((count + CW'(1)) == LAST_CNT);
            end
          end
        end
        S_DONE: begin
          // Stay here until blanking; no wrap back to entry 0.
          frame_done_out  <= 1'b1;
          digit_valid_out <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aux_display_reader.sv
// tb_aux_display_reader: randomized self-checking bench for aux_display_reader.
// Reference: per-frame expected nibble list built from memory contents with
// plain arithmetic; a monitor pops it on every handshake.

module tb_aux_display_reader;

  localparam int DW  = 16;
  localparam int AW  = 5;
  localparam int AE  = 10;
  localparam int NIB = DW / 4;

  logic          clk;
  logic          rst_n;
  logic          v_sync;
  logic [DW-1:0] aux_data;
  logic [AW-1:0] aux_raddress;
  logic [3:0]    digit;
  logic          digit_valid;
  logic          digit_ready;
  logic          digit_last;
  logic [AW-1:0] entry_index;
  logic          frame_done;

  aux_display_reader #(
    .DATA_WIDTH(DW), .AUX_ADDRESS_WIDTH(AW), .AUX_ELEMENTS(AE)
  ) dut (
    .clock_in(clk),
    .reset_in(rst_n),
    .v_sync_in(v_sync),
    .aux_data_in(aux_data),
    .aux_raddress_out(aux_raddress),
    .digit_out(digit),
    .digit_valid_out(digit_valid),
    .digit_ready_in(digit_ready),
    .digit_last_out(digit_last),
    .entry_index_out(entry_index),
    .frame_done_out(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Aux memory with one cycle of read latency.
  logic [DW-1:0] mem [32];
  always @(posedge clk) aux_data <= mem[aux_raddress];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0] d;
    logic       l;
    int         idx;
  } item_t;

  item_t q[$];
  int    ent_xfers[AE];

  function automatic int ref_len(input logic [DW-1:0] w);
`ifdef AUX_READER_ZERO_SUPPRESS_EN
    int n = 0;
    int v = int'(w);
    do begin
      n++;
      v = v / 16;
    end while (v != 0);
    return n;
`else
    return NIB;
`endif
  endfunction

  // Fills the expectation queue for one full frame; returns the cycle in
  // which frame_done should first be visible with ready held high.
  task automatic build_expect(output int exp_done);
    item_t it;
    logic [DW-1:0] w;
    int len;
    q.delete();
    for (int e = 0; e < AE; e++) ent_xfers[e] = 0;
    exp_done = 2;
    for (int e = 0; e < AE; e++) begin
      w   = mem[e];
      len = ref_len(w);
      exp_done += len + 2;
      for (int j = 0; j < len; j++) begin
        it.d   = w[4*(len-1-j) +: 4];
        it.l   = (j == len - 1);
        it.idx = e;
        q.push_back(it);
      end
    end
  endtask

  // ---------------- ready driver ----------------
  int rdy_mode = 0;
  initial begin
    digit_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      digit_ready = (rdy_mode == 0) ? 1'b1 : (($urandom % 2) == 1);
    end
  end

  // ---------------- monitor ----------------
  logic       stalled = 1'b0;
  logic [3:0] s_dig;
  logic       s_last;
  logic [AW-1:0] s_idx;

  always @(negedge clk) begin
    item_t it;
    if (stalled) begin
      check("hold_valid", 32'(digit_valid), 32'(1));
      check("hold_digit", 32'(digit), 32'(s_dig));
      check("hold_last",  32'(digit_last), 32'(s_last));
      check("hold_index", 32'(entry_index), 32'(s_idx));
    end
    stalled = digit_valid && !digit_ready && v_sync && rst_n;
    s_dig   = digit;
    s_last  = digit_last;
    s_idx   = entry_index;
    if (digit_valid && digit_ready && v_sync && rst_n) begin
      if (q.size() == 0) begin
        check("extra_nibble", 32'(1), 32'(0));
      end else begin
        it = q.pop_front();
        check("digit", 32'(digit), 32'(it.d));
        check("last",  32'(digit_last), 32'(it.l));
        check("index", 32'(entry_index), 32'(it.idx));
        if (it.idx >= 0 && it.idx < AE) ent_xfers[it.idx]++;
      end
    end
  end

  // ---------------- frame runner ----------------
  task automatic run_frame(input bit timed, input string name);
    int first_valid;
    int done_cyc;
    int exp_done;
    build_expect(exp_done);
    first_valid = 0;
    done_cyc    = 0;
    @(posedge clk);
    #1;
    v_sync = 1'b1;
    // Cycle k is the cycle that starts k-1 edges after the sampling edge.
    for (int k = 1; k <= 2000 && done_cyc == 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (first_valid == 0 && digit_valid) first_valid = k;
      if (frame_done) done_cyc = k;
    end
    check({name, "_first_valid_cycle"}, 32'(first_valid), 32'(3));
    check({name, "_done_seen"}, 32'(done_cyc != 0), 32'(1));
    if (timed) check({name, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
    check({name, "_nibbles_left"}, 32'(q.size()), 32'(0));
    repeat (3) begin
      @(negedge clk);
      check({name, "_end_done"},  32'(frame_done), 32'(1));
      check({name, "_end_valid"}, 32'(digit_valid), 32'(0));
      check({name, "_end_addr"},  32'(aux_raddress), 32'(AE - 1));
    end
    @(posedge clk);
    #1;
    v_sync = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({name, "_blank_done"},  32'(frame_done), 32'(0));
    check({name, "_blank_valid"}, 32'(digit_valid), 32'(0));
    check({name, "_blank_index"}, 32'(entry_index), 32'(0));
    check({name, "_blank_addr"},  32'(aux_raddress), 32'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int  exp_done;
    bit  hit;
    rst_n  = 1'b0;
    v_sync = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_digit", 32'(digit), 32'(0));
    check("rst_valid", 32'(digit_valid), 32'(0));
    check("rst_last",  32'(digit_last), 32'(0));
    check("rst_index", 32'(entry_index), 32'(0));
    check("rst_addr",  32'(aux_raddress), 32'(0));
    check("rst_done",  32'(frame_done), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic stream: aux[i] = 2i, ready high.
    for (int i = 0; i < AE; i++) mem[i] = 16'(2 * i);
    rdy_mode = 0;
    run_frame(1'b1, "basic");

    // Random backpressure, with the zero-suppression corner words first.
    mem[0] = 16'h0006;
    mem[1] = 16'h0000;
    mem[2] = 16'h0013;
    mem[3] = 16'hF000;
    for (int i = 4; i < AE; i++) mem[i] = 16'($urandom);
    rdy_mode = 1;
    run_frame(1'b0, "bp_a");
    for (int i = 0; i < AE; i++) mem[i] = 16'($urandom);
    run_frame(1'b0, "bp_b");
    rdy_mode = 0;

    // Blanking after two nibbles of entry 3.
    for (int i = 0; i < AE; i++) mem[i] = 16'($urandom);
    mem[3] = 16'h1000 | 16'($urandom_range(16'h0FFF, 0));
    build_expect(exp_done);
    @(posedge clk);
    #1;
    v_sync = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 300 && !hit; k++) begin
      @(posedge clk);
      #1;
      if (ent_xfers[3] == 2) begin
        v_sync = 1'b0;
        hit = 1'b1;
      end
    end
    check("blank_reached", 32'(hit), 32'(1));
    @(posedge clk);
    @(negedge clk);
    check("blank_mid_valid", 32'(digit_valid), 32'(0));
    check("blank_mid_index", 32'(entry_index), 32'(0));
    check("blank_mid_done",  32'(frame_done), 32'(0));
    check("blank_mid_xfers", 32'(ent_xfers[3]), 32'(2));
    q.delete();
    run_frame(1'b1, "after_blank");

    // Async reset in the middle of entry 5.
    for (int i = 0; i < AE; i++) mem[i] = 16'($urandom) | 16'h8000;
    build_expect(exp_done);
    @(posedge clk);
    #1;
    v_sync = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 300 && !hit; k++) begin
      @(negedge clk);
      if (ent_xfers[5] >= 2) hit = 1'b1;
    end
    check("rst_mid_reached", 32'(hit), 32'(1));
    #2;
    check("rst_mid_pre_valid", 32'(digit_valid), 32'(1));
    rst_n = 1'b0;
    #1;
    check("rst_mid_digit", 32'(digit), 32'(0));
    check("rst_mid_valid", 32'(digit_valid), 32'(0));
    check("rst_mid_last",  32'(digit_last), 32'(0));
    check("rst_mid_index", 32'(entry_index), 32'(0));
    check("rst_mid_addr",  32'(aux_raddress), 32'(0));
    check("rst_mid_done",  32'(frame_done), 32'(0));
    v_sync = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_idle_valid", 32'(digit_valid), 32'(0));
      check("post_rst_idle_addr",  32'(aux_raddress), 32'(0));
    end
    run_frame(1'b1, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
